interrupt_sequencer: RTL and testbench

Controls the CPU core's reset, NMI, IRQ and BRK entry sequences. It takes over the address and data path at an instruction boundary. For interrupts it pushes PC and status onto the page-1 stack. It then fetches the 16-bit vector and hands the new PC to the PC register. It sits beside the decoder and drives the A/D bus muxes, the SP decrement and the PC load while busy.

---
 rtl/interrupt_sequencer_if.sv | 13 +
 rtl/interrupt_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_sequencer_if.sv
// Memory-side bus of the interrupt sequencer: address, write data, read data and direction.
interface interrupt_sequencer_if #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0]  dout;
    logic [REG_WIDTH-1:0]  din;
    logic                  rw_n;

    modport master (output addr, output dout, output rw_n, input din);
    modport slave  (input addr, input dout, input rw_n, output din);
endinterface

// File: rtl/interrupt_sequencer.sv
// Reset/NMI/IRQ/BRK entry sequencer: pushes PC and status onto page 1,
// fetches the 16-bit vector and hands it to the PC register.
module interrupt_sequencer #(
    parameter int                    REG_WIDTH  = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] NMI_VEC    = 16'hFFFA,
    parameter logic [ADDR_WIDTH-1:0] RST_VEC    = 16'hFFFC,
    parameter logic [ADDR_WIDTH-1:0] IRQ_VEC    = 16'hFFFE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  irq_n,
    input  logic                  nmi_n,
    input  logic                  brk_req,
    input  logic                  instr_done,
    input  logic                  i_flag,
    input  logic [REG_WIDTH-1:0]  sp,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic [REG_WIDTH-1:0]  status_in,
    interrupt_sequencer_if.master bus,
    output logic                  busy,
    output logic                  sp_dec,
    output logic                  pc_load,
    output logic [ADDR_WIDTH-1:0] pc_vec,
    output logic                  set_i,
    output logic                  nmi_ack
);

    localparam logic [ADDR_WIDTH-REG_WIDTH-1:0] STACK_PAGE = 1;

    typedef enum logic [3:0] {
        RST_PCH, RST_PCL, RST_P, IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, LOAD
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] vec_q, vec_d;
    logic [ADDR_WIDTH-1:0] pc_vec_q, pc_vec_d;
    logic                  brk_q, brk_d;
    logic                  nmi_pending_q, nmi_pending_d;
    logic                  nmi_prev_q, nmi_prev_d;

    logic                  nmi_fall;
    logic                  irq_take;
    logic [ADDR_WIDTH-1:0] stack_addr;
    logic [REG_WIDTH-1:0]  pushed_status;

    assign nmi_fall   = nmi_prev_q & ~nmi_n;
    assign irq_take   = ~irq_n & ~i_flag;
    assign stack_addr = {STACK_PAGE, sp};
    assign pc_vec     = pc_vec_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RST_PCH;
            vec_q         <= RST_VEC;
            pc_vec_q      <= '0;
            brk_q         <= 1'b0;
            nmi_pending_q <= 1'b0;
            nmi_prev_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            vec_q         <= vec_d;
            pc_vec_q      <= pc_vec_d;
            brk_q         <= brk_d;
            nmi_pending_q <= nmi_pending_d;
            nmi_prev_q    <= nmi_prev_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        vec_d         = vec_q;
        pc_vec_d      = pc_vec_q;
        brk_d         = brk_q;
        nmi_prev_d    = nmi_n;
        nmi_pending_d = nmi_pending_q | nmi_fall;
        case (state_q)
            RST_PCH: state_d = RST_PCL;
            RST_PCL: state_d = RST_P;
            RST_P: begin
                vec_d   = RST_VEC;
                state_d = VEC_LO;
            end
            IDLE: begin
                // Priority: latched NMI edge, then BRK, then unmasked IRQ level.
                if (instr_done) begin
                    if (nmi_pending_q) begin
                        vec_d   = NMI_VEC;
                        brk_d   = 1'b0;
                        state_d = PUSH_PCH;
                    end else if (brk_req) begin
                        vec_d   = IRQ_VEC;
                        brk_d   = 1'b1;
                        state_d = PUSH_PCH;
                    end else if (irq_take) begin
                        vec_d   = IRQ_VEC;
                        brk_d   = 1'b0;
                        state_d = PUSH_PCH;
                    end
                end
            end
            PUSH_PCH: state_d = PUSH_PCL;
            PUSH_PCL: state_d = PUSH_P;
            PUSH_P: begin
                // An NMI arriving during the pushes steals the vector fetch.
                if (nmi_pending_q) begin
                    vec_d = NMI_VEC;
                end
                state_d = VEC_LO;
            end
            VEC_LO: begin
                pc_vec_d[REG_WIDTH-1:0] = bus.din;
                if (vec_q == NMI_VEC) begin
                    nmi_pending_d = nmi_fall;
                end
                state_d = VEC_HI;
            end
            VEC_HI: begin
                pc_vec_d[ADDR_WIDTH-1:REG_WIDTH] = bus.din;
                state_d = LOAD;
            end
            LOAD:    state_d = IDLE;
            default: state_d = RST_PCH;
        endcase
    end

    always_comb begin
        pushed_status    = status_in;
        pushed_status[5] = 1'b1;
        pushed_status[4] = brk_q;
        busy     = 1'b0;
        bus.addr = '0;
        bus.dout = '0;
        bus.rw_n = 1'b1;
        sp_dec   = 1'b0;
        pc_load  = 1'b0;
        set_i    = 1'b0;
        nmi_ack  = 1'b0;
        // Outputs follow reset combinationally so an abort is visible immediately.
        if (!reset_n) begin
            busy = 1'b1;
        end else begin
            case (state_q)
                RST_PCH, RST_PCL, RST_P: begin
                    busy     = 1'b1;
                    bus.addr = stack_addr;
                    sp_dec   = 1'b1;
                end
                PUSH_PCH: begin
                    busy     = 1'b1;
                    bus.addr = stack_addr;
                    bus.dout = pc_in[ADDR_WIDTH-1:REG_WIDTH];
                    bus.rw_n = 1'b0;
                    sp_dec   = 1'b1;
                end
                PUSH_PCL: begin
                    busy     = 1'b1;
                    bus.addr = stack_addr;
                    bus.dout = pc_in[REG_WIDTH-1:0];
                    bus.rw_n = 1'b0;
                    sp_dec   = 1'b1;
                end
                PUSH_P: begin
                    busy     = 1'b1;
                    bus.addr = stack_addr;
                    bus.dout = pushed_status;
                    bus.rw_n = 1'b0;
                    sp_dec   = 1'b1;
                end
                VEC_LO: begin
                    busy     = 1'b1;
                    bus.addr = vec_q;
                    nmi_ack  = (vec_q == NMI_VEC);
                end
                VEC_HI: begin
                    busy     = 1'b1;
                    bus.addr = vec_q + ADDR_WIDTH'(1);
                end
                LOAD: begin
                    busy    = 1'b1;
                    pc_load = 1'b1;
                    set_i   = 1'b1;
                end
                default: busy = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: vector table of boundary requests
// plus hand-written reset, NMI, hijack and abort sequences, checked via an event scoreboard.
module tb_interrupt_sequencer;

    localparam logic [3:0] KRD = 4'd1;
    localparam logic [3:0] KWR = 4'd2;
    localparam logic [3:0] KLD = 4'd3;

    typedef struct packed {
        logic [3:0]  kind;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    typedef struct {
        string       name;
        bit          iFlag;
        bit          irqN;
        bit          brk;
        logic [15:0] pc;
        logic [7:0]  status;
        logic [7:0]  sp;
        bit          taken;
        bit          bBit;
        logic [15:0] expVec;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        irq_n = 1'b1;
    logic        nmi_n = 1'b1;
    logic        brk_req = 1'b0;
    logic        instr_done = 1'b0;
    logic        i_flag = 1'b1;
    logic [7:0]  sp = 8'hFD;
    logic [15:0] pc_in = 16'h0000;
    logic [7:0]  status_in = 8'h00;
    logic        busy, sp_dec, pc_load, set_i, nmi_ack;
    logic [15:0] pc_vec;

    int errors = 0;
    int checks = 0;
    int busyCycles, setICount, nmiAckCount, cyc, loadCyc;
    ev_t expq[$];
    vec_t tbl[7];

    interrupt_sequencer_if bus ();

    function automatic logic [7:0] memRead(input logic [15:0] a);
        case (a)
            16'hFFFA: return 8'h00;
            16'hFFFB: return 8'h90;
            16'hFFFC: return 8'h34;
            16'hFFFD: return 8'h12;
            16'hFFFE: return 8'h00;
            16'hFFFF: return 8'h80;
            default:  return 8'hEE;
        endcase
    endfunction

    assign bus.din = memRead(bus.addr);

    interrupt_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irq_n      (irq_n),
        .nmi_n      (nmi_n),
        .brk_req    (brk_req),
        .instr_done (instr_done),
        .i_flag     (i_flag),
        .sp         (sp),
        .pc_in      (pc_in),
        .status_in  (status_in),
        .bus        (bus.master),
        .busy       (busy),
        .sp_dec     (sp_dec),
        .pc_load    (pc_load),
        .pc_vec     (pc_vec),
        .set_i      (set_i),
        .nmi_ack    (nmi_ack)
    );

    always #5 clk = ~clk;

    function automatic ev_t mkEv(input logic [3:0] k, input logic [15:0] a, input logic [15:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge, then let the SP model follow sp_dec.
    task automatic tick();
        ev_t act;
        logic dec;
        @(negedge clk);
        if (busy === 1'b1) busyCycles++;
        if (set_i === 1'b1) setICount++;
        if (nmi_ack === 1'b1) nmiAckCount++;
        if (sp_dec === 1'b1 || pc_load === 1'b1) begin
            if (pc_load === 1'b1) begin
                act = mkEv(KLD, 16'h0000, pc_vec);
                loadCyc = cyc;
            end else begin
                act = mkEv(bus.rw_n ? KRD : KWR, bus.addr, {8'h00, bus.dout});
            end
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected bus event: got %h expected none", act);
            end else begin
                checkOutput("bus event", act, expq.pop_front());
            end
        end
        dec = sp_dec;
        @(posedge clk);
        #1;
        if (dec === 1'b1) sp = sp - 8'd1;
        cyc++;
    endtask

    task automatic clearCounters(input int startCyc);
        busyCycles  = 0;
        setICount   = 0;
        nmiAckCount = 0;
        loadCyc     = -1;
        cyc         = startCyc;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " busy"},   36'(busy),     36'd1);
        checkOutput({tag, " rw_n"},   36'(bus.rw_n), 36'd1);
        checkOutput({tag, " addr"},   36'(bus.addr), 36'd0);
        checkOutput({tag, " dout"},   36'(bus.dout), 36'd0);
        checkOutput({tag, " pc_vec"}, 36'(pc_vec),   36'd0);
        checkOutput({tag, " strobes"}, 36'({sp_dec, pc_load, set_i, nmi_ack}), 36'd0);
    endtask

    task automatic pushResetSequence(input logic [7:0] startSp);
        logic [7:0] s;
        s = startSp;
        for (int i = 0; i < 3; i++) begin
            expq.push_back(mkEv(KRD, {8'h01, s}, 16'h0000));
            s = s - 8'd1;
        end
        expq.push_back(mkEv(KLD, 16'h0000, 16'h1234));
    endtask

    task automatic pushEntry(input logic [7:0] startSp, input logic [15:0] pc, input logic [7:0] st,
                             input bit b, input logic [15:0] vec);
        logic [7:0] s;
        s = startSp;
        expq.push_back(mkEv(KWR, {8'h01, s}, {8'h00, pc[15:8]}));
        s = s - 8'd1;
        expq.push_back(mkEv(KWR, {8'h01, s}, {8'h00, pc[7:0]}));
        s = s - 8'd1;
        expq.push_back(mkEv(KWR, {8'h01, s}, {8'h00, st[7:6], 1'b1, b, st[3:0]}));
        expq.push_back(mkEv(KLD, 16'h0000, vec));
    endtask

    task automatic checkSequenceEnd(input string tag, input bit taken, input int nmiAcks, input int loadAt);
        checkOutput({tag, " queue drained"}, 36'(expq.size()), 36'd0);
        checkOutput({tag, " busy cycles"},   36'(busyCycles), taken ? 36'd6 : 36'd0);
        checkOutput({tag, " set_i pulses"},  36'(setICount),  taken ? 36'd1 : 36'd0);
        checkOutput({tag, " nmi_ack pulses"}, 36'(nmiAckCount), 36'(nmiAcks));
        checkOutput({tag, " load cycle"},    36'(loadCyc), taken ? 36'(loadAt) : 36'(-1));
        checkOutput({tag, " busy idle"},     36'(busy), 36'd0);
        expq.delete();
    endtask

    task automatic pulseBoundary();
        clearCounters(0);
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
        brk_req    = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        i_flag    = v.iFlag;
        irq_n     = v.irqN;
        brk_req   = v.brk;
        pc_in     = v.pc;
        status_in = v.status;
        sp        = v.sp;
        if (v.taken) pushEntry(v.sp, v.pc, v.status, v.bBit, v.expVec);
        pulseBoundary();
        irq_n = 1'b1;
        repeat (8) tick();
        checkSequenceEnd(v.name, v.taken, 0, 6);
    endtask

    initial begin
        tbl[0] = '{"irq",           1'b0, 1'b0, 1'b0, 16'hC123, 8'h81, 8'hFF, 1'b1, 1'b0, 16'h8000};
        tbl[1] = '{"irq_masked",    1'b1, 1'b0, 1'b0, 16'hC123, 8'h81, 8'hFF, 1'b0, 1'b0, 16'h0000};
        tbl[2] = '{"brk",           1'b1, 1'b1, 1'b1, 16'h4567, 8'h00, 8'h80, 1'b1, 1'b1, 16'h8000};
        tbl[3] = '{"brk_over_irq",  1'b0, 1'b0, 1'b1, 16'h1357, 8'hC3, 8'h40, 1'b1, 1'b1, 16'h8000};
        tbl[4] = '{"no_request",    1'b0, 1'b1, 1'b0, 16'h2222, 8'h00, 8'h70, 1'b0, 1'b0, 16'h0000};
        tbl[5] = '{"irq_sp_wrap",   1'b0, 1'b0, 1'b0, 16'h0F0E, 8'h00, 8'h01, 1'b1, 1'b0, 16'h8000};
        tbl[6] = '{"irq_status_ff", 1'b0, 1'b0, 1'b0, 16'hFFFF, 8'hFF, 8'h30, 1'b1, 1'b0, 16'h8000};

        // Power-on reset: three dummy stack reads then the reset vector.
        #2 reset_n = 1'b0;
        #1 checkResetValues("por");
        clearCounters(0);
        tick();
        tick();
        sp = 8'hFD;
        pushResetSequence(8'hFD);
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        clearCounters(1);
        repeat (8) tick();
        checkSequenceEnd("reset", 1'b1, 0, 6);
        checkOutput("reset sp after", 36'(sp), 36'h0FA);

        for (int i = 0; i < 7; i++) applyStimulus(tbl[i]);

        // NMI held low across two boundaries: serviced exactly once.
        i_flag = 1'b1; irq_n = 1'b1;
        nmi_n = 1'b0;
        clearCounters(0);
        tick();
        tick();
        sp = 8'hFF; pc_in = 16'h2000; status_in = 8'h04;
        pushEntry(8'hFF, 16'h2000, 8'h04, 1'b0, 16'h9000);
        pulseBoundary();
        repeat (8) tick();
        checkSequenceEnd("nmi", 1'b1, 1, 6);
        pulseBoundary();
        repeat (8) tick();
        checkSequenceEnd("nmi_held", 1'b0, 0, 6);
        nmi_n = 1'b1;
        tick();

        // BRK hijacked by an NMI edge during PUSH_PCL.
        sp = 8'hF0; pc_in = 16'hABCD; status_in = 8'h00;
        pushEntry(8'hF0, 16'hABCD, 8'h00, 1'b1, 16'h9000);
        brk_req = 1'b1;
        pulseBoundary();
        tick();
        nmi_n = 1'b0;
        repeat (7) tick();
        checkSequenceEnd("brk_hijack", 1'b1, 1, 6);
        pulseBoundary();
        repeat (8) tick();
        checkSequenceEnd("after_hijack", 1'b0, 0, 6);
        nmi_n = 1'b1;
        tick();

        // Reset pulsed during PUSH_P of an IRQ: abort, then full reset sequence.
        i_flag = 1'b0; irq_n = 1'b0;
        sp = 8'hFF; pc_in = 16'hC123; status_in = 8'h81;
        expq.push_back(mkEv(KWR, 16'h01FF, 16'h00C1));
        expq.push_back(mkEv(KWR, 16'h01FE, 16'h0023));
        pulseBoundary();
        irq_n = 1'b1;
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1 checkResetValues("abort");
        checkOutput("abort queue drained", 36'(expq.size()), 36'd0);
        checkOutput("abort no load", 36'(loadCyc), 36'(-1));
        tick();
        tick();
        sp = 8'hFD;
        pushResetSequence(8'hFD);
        reset_n = 1'b1;
        clearCounters(1);
        repeat (8) tick();
        checkSequenceEnd("abort_reset", 1'b1, 0, 6);
        checkOutput("abort pc_vec", 36'(pc_vec), 36'h1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
